// File: rtl/tpu_drv_pkg.sv
// Shared constants, FSM encoding and error causes for the TPU host driver.
package tpu_drv_pkg;

    localparam int unsigned TPU_DW      = 128;
    localparam int unsigned TPU_AW      = 10;
    localparam int unsigned TPU_NROWS   = 16;
    localparam int unsigned TPU_MAX_K   = 144;
    localparam int unsigned TPU_TIMEOUT = 512;
    localparam int unsigned TPU_KW      = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StCollect,
        StDone
    } state_e;

    // Completion causes; anything other than ERR_NONE raises err with cmd_done.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_KLEN    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_SHORT   = 2'd3;

    function automatic logic klen_legal(input logic [TPU_KW-1:0] k, input int unsigned max_k);
        return (k != '0) && (32'(k) <= max_k);
    endfunction

endpackage

// File: rtl/tpu_drv_rdpipe.sv
// Source-buffer address generator plus 2-stage alignment pipe: the read issued in
// cycle n (1-cycle RAM latency) is presented to the TPU, registered, in cycle n+2.
module tpu_drv_rdpipe #(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 10,
    parameter int unsigned KW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [KW-1:0] i_k_len,
    input  logic [AW-1:0] i_a_base,
    input  logic [AW-1:0] i_w_base,
    output logic          o_rd_en,
    output logic [AW-1:0] o_a_rd_addr,
    output logic [AW-1:0] o_w_rd_addr,
    input  logic [DW-1:0] i_a_rd_data,
    input  logic [DW-1:0] i_w_rd_data,
    output logic          o_valid,
    output logic [DW-1:0] o_mat,
    output logic [DW-1:0] o_wei,
    output logic          o_last
);

    logic [KW-1:0] r_remain;
    logic [AW-1:0] r_a_addr;
    logic [AW-1:0] r_w_addr;
    logic          r_v1;
    logic          r_v2;
    logic [DW-1:0] r_mat;
    logic [DW-1:0] r_wei;
    logic          w_rd_en;

    assign w_rd_en = (r_remain != '0);

    // Address counters and the valid/data alignment registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_remain <= '0;
            r_a_addr <= '0;
            r_w_addr <= '0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_mat    <= '0;
            r_wei    <= '0;
        end else begin
            if (i_load) begin
                r_remain <= i_k_len;
                r_a_addr <= i_a_base;
                r_w_addr <= i_w_base;
            end else if (w_rd_en) begin
                // Addresses wrap naturally at 2^AW.
                r_remain <= r_remain - KW'(1);
                r_a_addr <= r_a_addr + AW'(1);
                r_w_addr <= r_w_addr + AW'(1);
            end
            r_v1  <= w_rd_en;
            r_v2  <= r_v1;
            // Data is zeroed whenever the word is not valid.
            r_mat <= r_v1 ? i_a_rd_data : '0;
            r_wei <= r_v1 ? i_w_rd_data : '0;
        end
    end

    assign o_rd_en     = w_rd_en;
    assign o_a_rd_addr = r_a_addr;
    assign o_w_rd_addr = r_w_addr;
    assign o_valid     = r_v2;
    assign o_mat       = r_mat;
    assign o_wei       = r_wei;
    // Last word is on the TPU bus and nothing is left in flight behind it.
    assign o_last      = (r_remain == '0) && !r_v1 && r_v2;

endmodule

// File: rtl/tpu_host_driver.sv
// Host-side initiator for the systolic TPU: streams k_len activation/weight words,
// waits for the result, and stores NROWS result rows into the result buffer.
module tpu_host_driver
    import tpu_drv_pkg::*;
#(
    parameter int unsigned DW      = TPU_DW,
    parameter int unsigned AW      = TPU_AW,
    parameter int unsigned NROWS   = TPU_NROWS,
    parameter int unsigned MAX_K   = TPU_MAX_K,
    parameter int unsigned TIMEOUT = TPU_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [TPU_KW-1:0] i_k_len,
    input  logic [AW-1:0]     i_a_base,
    input  logic [AW-1:0]     i_w_base,
    input  logic [AW-1:0]     i_r_base,
    output logic              o_busy,
    output logic              o_cmd_done,
    output logic              o_err,
    output logic              o_buf_rd_en,
    output logic [AW-1:0]     o_a_rd_addr,
    output logic [AW-1:0]     o_w_rd_addr,
    input  logic [DW-1:0]     i_a_rd_data,
    input  logic [DW-1:0]     i_w_rd_data,
    output logic              o_tpu_in_valid,
    output logic [DW-1:0]     o_tpu_mat_di,
    output logic [DW-1:0]     o_tpu_wei_di,
    input  logic              i_tpu_out_valid,
    input  logic [DW-1:0]     i_tpu_do,
    input  logic              i_tpu_done,
    output logic              o_res_wr_en,
    output logic [AW-1:0]     o_res_wr_addr,
    output logic [DW-1:0]     o_res_wr_data
);

    localparam int unsigned RW = $clog2(NROWS);
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [1:0]    r_cause;
    logic [1:0]    w_cause_nxt;
    logic [RW-1:0] r_row;
    logic [TW-1:0] r_tmo;
    logic [AW-1:0] r_r_base;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          w_accept;
    logic          w_capture;
    logic          w_last_in;

    tpu_drv_rdpipe #(
        .DW(DW),
        .AW(AW),
        .KW(TPU_KW)
    ) u_rdpipe (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_k_len    (i_k_len),
        .i_a_base   (i_a_base),
        .i_w_base   (i_w_base),
        .o_rd_en    (o_buf_rd_en),
        .o_a_rd_addr(o_a_rd_addr),
        .o_w_rd_addr(o_w_rd_addr),
        .i_a_rd_data(i_a_rd_data),
        .i_w_rd_data(i_w_rd_data),
        .o_valid    (o_tpu_in_valid),
        .o_mat      (o_tpu_mat_di),
        .o_wei      (o_tpu_wei_di),
        .o_last     (w_last_in)
    );

    // Next-state, error cause and per-cycle strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (klen_legal(i_k_len, MAX_K)) begin
                        w_accept    = 1'b1;
                        w_cause_nxt = ERR_NONE;
                        w_state_nxt = StRead;
                    end else begin
                        w_cause_nxt = ERR_KLEN;
                        w_state_nxt = StDone;
                    end
                end
            end
            // Stay here until the pipe has drained, so early out_valid is ignored.
            StRead: begin
                if (w_last_in) begin
                    w_state_nxt = StWait;
                end
            end
            StWait, StCollect: begin
                if (i_tpu_out_valid) begin
                    w_capture = 1'b1;
                    if (r_row == RW'(NROWS - 1)) begin
                        w_state_nxt = StDone;
                    end else if (i_tpu_done) begin
                        w_cause_nxt = ERR_SHORT;
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt = StCollect;
                    end
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_cause_nxt = ERR_TIMEOUT;
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and error-cause registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cause <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // Row counter, idle-cycle timeout counter and registered result write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_r_base  <= '0;
            r_row     <= '0;
            r_tmo     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_capture;
            if (w_accept) begin
                r_r_base <= i_r_base;
                r_row    <= '0;
            end else if (w_capture) begin
                r_row <= r_row + RW'(1);
            end
            if (w_capture) begin
                r_wr_addr <= r_r_base + AW'(r_row);
                r_wr_data <= i_tpu_do;
            end
            // Counts cycles without a row; restarts on every captured row.
            if (r_state == StRead || w_capture) begin
                r_tmo <= TW'(1);
            end else if (r_state == StWait || r_state == StCollect) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    assign o_busy        = (r_state != StIdle);
    assign o_cmd_done    = (r_state == StDone);
    assign o_err         = (r_state == StDone) && (r_cause != ERR_NONE);
    assign o_res_wr_en   = r_wr_en;
    assign o_res_wr_addr = r_wr_addr;
    assign o_res_wr_data = r_wr_data;

endmodule

// File: tb/tb_tpu_host_driver.sv
// Bench for tpu_host_driver: buffer and TPU models, event monitor, and a
// transaction-level expectation built from the command parameters.
module tb_tpu_host_driver;

    localparam int AW    = 10;
    localparam int DW    = 128;
    localparam int NR    = 16;
    localparam int MAXK  = 144;
    localparam int TMO   = 512;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    k_len;
    logic [AW-1:0] a_base, w_base, r_base;
    logic          busy, cmd_done, err, rd_en;
    logic [AW-1:0] a_addr, w_addr;
    logic [DW-1:0] a_data, w_data;
    logic          in_valid;
    logic [DW-1:0] mat, wei;
    logic          out_valid;
    logic [DW-1:0] tpu_do;
    logic          tpu_done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    tpu_host_driver dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_k_len        (k_len),
        .i_a_base       (a_base),
        .i_w_base       (w_base),
        .i_r_base       (r_base),
        .o_busy         (busy),
        .o_cmd_done     (cmd_done),
        .o_err          (err),
        .o_buf_rd_en    (rd_en),
        .o_a_rd_addr    (a_addr),
        .o_w_rd_addr    (w_addr),
        .i_a_rd_data    (a_data),
        .i_w_rd_data    (w_data),
        .o_tpu_in_valid (in_valid),
        .o_tpu_mat_di   (mat),
        .o_tpu_wei_di   (wei),
        .i_tpu_out_valid(out_valid),
        .i_tpu_do       (tpu_do),
        .i_tpu_done     (tpu_done),
        .o_res_wr_en    (wr_en),
        .o_res_wr_addr  (wr_addr),
        .o_res_wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    // Source buffers with 1-cycle synchronous read.
    logic [DW-1:0] a_mem [DEPTH];
    logic [DW-1:0] w_mem [DEPTH];
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= a_mem[a_addr];
            w_data <= w_mem[w_addr];
        end
    end

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int            rel;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } ev_t;

    ev_t rd_q[$], iv_q[$], wr_q[$], done_q[$], row_q[$];
    ev_t mon_e;
    int  t0;
    bit  mon_on = 1'b0;
    bit  tpu_active = 1'b0;
    int  zero_viol, busy_first, busy_last;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Monitor: cycle numbers are relative to the cycle in which start was driven.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_e.rel = ecnt - t0;
            if (rd_en) begin
                mon_e.d0 = DW'(a_addr);
                mon_e.d1 = DW'(w_addr);
                rd_q.push_back(mon_e);
            end
            if (in_valid) begin
                mon_e.d0 = mat;
                mon_e.d1 = wei;
                iv_q.push_back(mon_e);
            end else if (mat != '0 || wei != '0) begin
                zero_viol++;
            end
            if (wr_en) begin
                mon_e.d0 = DW'(wr_addr);
                mon_e.d1 = wr_data;
                wr_q.push_back(mon_e);
            end
            if (cmd_done) begin
                mon_e.d0 = DW'(err);
                mon_e.d1 = DW'(busy);
                done_q.push_back(mon_e);
            end
            if (busy) begin
                if (busy_first < 0) busy_first = mon_e.rel;
                busy_last = mon_e.rel;
            end
        end
    end

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // TPU model: answers once the input stream has ended.
    task automatic tpu_respond(input int delay, input int nrows, input int extra, input bit gaps);
        int  guard;
        ev_t e;
        guard = 0;
        while (!in_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (in_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (nrows > 0) begin
            repeat (delay - 1) @(negedge clk);
            for (int r = 0; r < nrows; r++) begin
                if (gaps && r > 0 && $urandom_range(0, 3) == 0) begin
                    out_valid = 1'b0;
                    tpu_done  = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                out_valid = 1'b1;
                tpu_do    = rnd_word();
                tpu_done  = (r == nrows - 1);
                e.rel = ecnt - t0;
                e.d0  = tpu_do;
                e.d1  = '0;
                row_q.push_back(e);
                @(negedge clk);
            end
            for (int x = 0; x < extra; x++) begin
                out_valid = 1'b1;
                tpu_done  = 1'b1;
                tpu_do    = rnd_word();
                @(negedge clk);
            end
            out_valid = 1'b0;
            tpu_done  = 1'b0;
            tpu_do    = '0;
        end
        tpu_active = 1'b0;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        iv_q.delete();
        wr_q.delete();
        done_q.delete();
        row_q.delete();
        zero_viol  = 0;
        busy_first = -1;
        busy_last  = -1;
    endtask

    task automatic run_cmd(input string name, input int k, input int ab, input int wb, input int rb,
                           input int delay, input int nrows, input int extra, input bit gaps);
        bit legal, exp_err;
        int n, exp_done_rel, guard, nw;
        legal = (k >= 1 && k <= MAXK);
        clear_mon();
        @(negedge clk);
        start  = 1'b1;
        k_len  = 8'(k);
        a_base = AW'(ab);
        w_base = AW'(wb);
        r_base = AW'(rb);
        t0     = ecnt;
        mon_on = 1'b1;
        if (legal) begin
            tpu_active = 1'b1;
            fork
                tpu_respond(delay, nrows, extra, gaps);
            join_none
        end
        @(negedge clk);
        start  = 1'b0;
        k_len  = 8'($urandom);
        a_base = AW'($urandom);
        w_base = AW'($urandom);
        r_base = AW'($urandom);
        @(negedge clk);
        // A start while busy must be ignored.
        if (legal) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (done_q.size() == 0 && guard < k + TMO + 400) begin
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (tpu_active && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        mon_on = 1'b0;

        n = legal ? k : 0;
        check_val({name, "_rd_count"}, DW'(rd_q.size()), DW'(n));
        for (int i = 0; i < n && i < rd_q.size(); i++) begin
            check_val({name, "_rd_rel"}, DW'(rd_q[i].rel), DW'(1 + i));
            check_val({name, "_a_addr"}, rd_q[i].d0, DW'((ab + i) % DEPTH));
            check_val({name, "_w_addr"}, rd_q[i].d1, DW'((wb + i) % DEPTH));
        end
        check_val({name, "_iv_count"}, DW'(iv_q.size()), DW'(n));
        for (int i = 0; i < n && i < iv_q.size(); i++) begin
            check_val({name, "_iv_rel"}, DW'(iv_q[i].rel), DW'(3 + i));
            check_val({name, "_mat"}, iv_q[i].d0, a_mem[(ab + i) % DEPTH]);
            check_val({name, "_wei"}, iv_q[i].d1, w_mem[(wb + i) % DEPTH]);
        end
        check_val({name, "_zero_when_idle"}, DW'(zero_viol), '0);

        nw = (row_q.size() < NR) ? row_q.size() : NR;
        check_val({name, "_wr_count"}, DW'(wr_q.size()), DW'(nw));
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            check_val({name, "_wr_rel"}, DW'(wr_q[i].rel), DW'(row_q[i].rel + 1));
            check_val({name, "_wr_addr"}, wr_q[i].d0, DW'((rb + i) % DEPTH));
            check_val({name, "_wr_data"}, wr_q[i].d1, row_q[i].d0);
        end

        if (!legal) begin
            exp_done_rel = 1;
            exp_err      = 1'b1;
        end else if (nrows == 0) begin
            exp_done_rel = k + 2 + TMO;
            exp_err      = 1'b1;
        end else begin
            exp_done_rel = row_q[row_q.size() - 1].rel + 1;
            exp_err      = (nrows < NR);
        end
        check_val({name, "_done_count"}, DW'(done_q.size()), DW'(1));
        if (done_q.size() > 0) begin
            check_val({name, "_done_rel"}, DW'(done_q[0].rel), DW'(exp_done_rel));
            check_val({name, "_err"}, done_q[0].d0, DW'(exp_err));
            check_val({name, "_busy_at_done"}, done_q[0].d1, DW'(1));
        end
        check_val({name, "_busy_first"}, DW'(busy_first), DW'(1));
        check_val({name, "_busy_last"}, DW'(busy_last), DW'(exp_done_rel));
    endtask

    task automatic check_all_zero(input string name);
        check_val({name, "_busy"}, DW'(busy), '0);
        check_val({name, "_cmd_done"}, DW'(cmd_done), '0);
        check_val({name, "_err"}, DW'(err), '0);
        check_val({name, "_rd_en"}, DW'(rd_en), '0);
        check_val({name, "_a_addr"}, DW'(a_addr), '0);
        check_val({name, "_w_addr"}, DW'(w_addr), '0);
        check_val({name, "_in_valid"}, DW'(in_valid), '0);
        check_val({name, "_mat"}, mat, '0);
        check_val({name, "_wei"}, wei, '0);
        check_val({name, "_wr_en"}, DW'(wr_en), '0);
        check_val({name, "_wr_addr"}, DW'(wr_addr), '0);
        check_val({name, "_wr_data"}, wr_data, '0);
    endtask

    // Reset in cycle 5 of a k_len=20 stream, then a fresh command 2 cycles later.
    task automatic reset_midstream();
        clear_mon();
        @(negedge clk);
        start  = 1'b1;
        k_len  = 8'd20;
        a_base = AW'(200);
        w_base = AW'(600);
        r_base = AW'(40);
        t0     = ecnt;
        mon_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while ((ecnt - t0) < 5) @(negedge clk);
        check_val("rst_in_valid_before", DW'(in_valid), DW'(1));
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        mon_on = 1'b0;
        check_val("rst_no_done", DW'(done_q.size()), '0);
        check_val("rst_no_wr", DW'(wr_q.size()), '0);
        run_cmd("t6_after_rst", 20, 200, 600, 40, 3, 16, 0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        a_base    = '0;
        w_base    = '0;
        r_base    = '0;
        out_valid = 1'b0;
        tpu_do    = '0;
        tpu_done  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            a_mem[i] = rnd_word();
            w_mem[i] = rnd_word();
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            b = 8'(i + 1);
            a_mem[100 + i] = {16{b}};
            w_mem[300 + i] = {16{b}};
        end
        run_cmd("t1_k9", 9, 100, 300, 500, 4, 16, 0, 1'b0);
        run_cmd("t2_wrap", 144, 1020, 900, 1015, 7, 16, 0, 1'b0);
        run_cmd("t3_k0", 0, 10, 20, 30, 1, 16, 0, 1'b0);
        run_cmd("t3_k145", 145, 10, 20, 30, 1, 16, 0, 1'b0);
        run_cmd("t3_k255", 255, 10, 20, 30, 1, 16, 0, 1'b0);
        run_cmd("t4_timeout", 12, 50, 60, 70, 1, 0, 0, 1'b0);
        run_cmd("t5_short", 16, 400, 410, 420, 3, 11, 0, 1'b0);
        run_cmd("t5_hold", 5, 700, 710, 720, 2, 16, 5, 1'b0);
        run_cmd("t5_short_hold", 7, 800, 810, 1020, 1, 4, 3, 1'b0);
        run_cmd("k1", 1, 1023, 1023, 1023, 1, 16, 0, 1'b1);
        reset_midstream();

        for (int n = 0; n < 10; n++) begin
            int k, nr;
            k  = $urandom_range(1, MAXK);
            nr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NR - 1) : NR;
            run_cmd("rand", k, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                    $urandom_range(0, DEPTH - 1), $urandom_range(1, 30), nr,
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
